spi_xfer_ctrl: RTL

Transfer sequencer for the SPI master. It sits between the register/shift-register logic and the SPI clock generator.
- Drives the clock generator's `go` and `last_clk` inputs.
- Consumes its `pos_edge`/`neg_edge` flags.
- Produces chip-select timing plus load/shift/sample strobes for the shift register, for all four CPOL/CPHA modes.
- Counts bits and reports busy/done for one character of 1..2^C_LEN_WIDTH bits.

---
 rtl/spi_xfer_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer for the SPI master: CS timing, shift-register strobes,
// bit counting and busy/done handshake for one character in any CPOL/CPHA mode.
module spi_xfer_ctrl #(
    parameter int C_LEN_WIDTH = 5,
    parameter int C_CS_DLY    = 2
) (
    input  logic                   i_sysclk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic [C_LEN_WIDTH-1:0] i_char_len,
    input  logic                   i_cpol,
    input  logic                   i_cpha,
    input  logic                   i_pos_edge,
    input  logic                   i_neg_edge,
    output logic                   o_go,
    output logic                   o_last_clk,
    output logic                   o_cs_n,
    output logic                   o_load,
    output logic                   o_shift_en,
    output logic                   o_sample_en,
    output logic [C_LEN_WIDTH:0]   o_bit_cnt,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int LW = C_LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_cpol;
    logic            r_cpha;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_trail_cnt;
    logic [LW-1:0]   r_bit_cnt;
    logic [3:0]      r_dly;

    logic            r_go;
    logic            r_last_clk;
    logic            r_cs_n;
    logic            r_load;
    logic            r_shift_en;
    logic            r_sample_en;
    logic            r_busy;
    logic            r_done;

    logic            w_go_nxt;
    logic            w_last_clk_nxt;
    logic            w_cs_n_nxt;
    logic            w_load_nxt;
    logic            w_shift_nxt;
    logic            w_sample_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic            w_accept;
    logic            w_lead;
    logic            w_trail;
    logic            w_lead_x;
    logic            w_trail_x;
    logic            w_last_bit;
    logic            w_dly_done;
    logic [LW-1:0]   w_len_in;

    // A char_len of zero stands for the full 2^C_LEN_WIDTH-bit character.
    assign w_len_in   = (i_char_len == '0) ? {1'b1, {C_LEN_WIDTH{1'b0}}}
                                           : {1'b0, i_char_len};
    assign w_accept   = (r_state == S_IDLE) && i_enable && i_start;
    assign w_lead     = r_cpol ? i_neg_edge : i_pos_edge;
    assign w_trail    = r_cpol ? i_pos_edge : i_neg_edge;
    assign w_lead_x   = (r_state == S_XFER) && w_lead;
    assign w_trail_x  = (r_state == S_XFER) && w_trail;
    assign w_last_bit = (r_trail_cnt == (r_len - LW'(1)));
    assign w_dly_done = (r_dly == 4'(C_CS_DLY - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)              w_state_nxt = S_SETUP;
            S_SETUP: if (w_dly_done)            w_state_nxt = S_XFER;
            S_XFER:  if (w_trail && w_last_bit) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_dly_done)            w_state_nxt = S_DONE;
            S_DONE:                             w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
        if (!i_enable && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end

        w_go_nxt       = (w_state_nxt == S_XFER);
        w_cs_n_nxt     = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_XFER) ||
                           (w_state_nxt == S_HOLD));
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_load_nxt     = w_accept;
        w_last_clk_nxt = 1'b0;
        if (w_state_nxt == S_XFER) begin
            w_last_clk_nxt = r_last_clk || (w_lead_x && w_last_bit);
        end

        // The final trail edge in CPHA=0 has no following bit to drive.
        w_sample_nxt = i_enable && (r_cpha ? w_trail_x : w_lead_x);
        w_shift_nxt  = i_enable && (r_cpha ? w_lead_x : (w_trail_x && !w_last_bit));
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_go        <= 1'b0;
            r_last_clk  <= 1'b0;
            r_cs_n      <= 1'b1;
            r_load      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_go        <= w_go_nxt;
            r_last_clk  <= w_last_clk_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_load      <= w_load_nxt;
            r_shift_en  <= w_shift_nxt;
            r_sample_en <= w_sample_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_len       <= '0;
            r_trail_cnt <= '0;
            r_bit_cnt   <= '0;
            r_dly       <= '0;
        end else begin
            if (w_accept) begin
                r_cpol      <= i_cpol;
                r_cpha      <= i_cpha;
                r_len       <= w_len_in;
                r_trail_cnt <= '0;
                r_bit_cnt   <= '0;
            end else begin
                if (r_sample_en && (r_bit_cnt != r_len)) begin
                    r_bit_cnt <= r_bit_cnt + LW'(1);
                end
                if (w_trail_x && i_enable) begin
                    r_trail_cnt <= r_trail_cnt + LW'(1);
                end
            end

            // One counter serves both the CS setup and the CS hold interval.
            if (w_state_nxt != r_state) begin
                r_dly <= '0;
            end else if ((r_state == S_SETUP) || (r_state == S_HOLD)) begin
                r_dly <= r_dly + 4'd1;
            end
        end
    end

    assign o_go        = r_go;
    assign o_last_clk  = r_last_clk;
    assign o_cs_n      = r_cs_n;
    assign o_load      = r_load;
    assign o_shift_en  = r_shift_en;
    assign o_sample_en = r_sample_en;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
